// File: rtl/level_mem_arbiter_pkg.sv
// Shared definitions for the level-memory arbiter: default widths, requester IDs,
// round-robin pointer states and the in-flight read tag.
package level_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 4;

  typedef enum logic {
    ID_BG  = 1'b0,
    ID_COL = 1'b1
  } req_id_t;

  typedef enum logic {
    LAST_BG  = 1'b0,
    LAST_COL = 1'b1
  } ptr_state_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/level_mem_arbiter_tag_pipe.sv
// Requester-ID shift register that follows each granted read through the memory
// pipeline, so results are steered back in grant order.
module level_arb_tag_pipe
  import level_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] id_reg;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      valid_reg <= '0;
      id_reg    <= '0;
    end else begin
      valid_reg <= {valid_reg[DEPTH-2:0], tag_in.valid};
      id_reg    <= {id_reg[DEPTH-2:0], tag_in.id};
    end
  end

  always_comb begin
    tag_out.valid = valid_reg[DEPTH-1];
    tag_out.id    = req_id_t'(id_reg[DEPTH-1]);
  end

  assign any_valid = |valid_reg;

endmodule

// File: rtl/level_mem_arbiter.sv
// Shares one level-memory read port between the background drawer and the collision
// detector. Define LEVEL_ARB_FIXED_PRIO_EN to make col win every tie instead of round-robin.
module level_mem_arbiter
  import level_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              bg_gnt,
  output logic              bg_valid,
  output logic [DATA_W-1:0] bg_data,
  input  logic              col_req,
  input  logic [ADDR_W-1:0] col_addr,
  output logic              col_gnt,
  output logic              col_valid,
  output logic [DATA_W-1:0] col_data,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  localparam int TAG_DEPTH = READ_LATENCY + 1;

  logic    grant_any;
  req_id_t grant_id;
  tag_t    tag_in;
  tag_t    tag_out;
  logic    tags_busy;

`ifdef LEVEL_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = bg_req | col_req;
    grant_id  = col_req ? ID_COL : ID_BG;
  end
`else
  ptr_state_t ptr_reg;
  ptr_state_t ptr_next;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ptr_reg <= LAST_COL;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) begin
      ptr_next = (grant_id == ID_COL) ? LAST_COL : LAST_BG;
    end
  end

  // On a tie the requester not granted most recently wins.
  always_comb begin
    grant_any = bg_req | col_req;
    grant_id  = ID_BG;
    if (col_req && (!bg_req || ptr_reg == LAST_BG)) begin
      grant_id = ID_COL;
    end
  end
`endif

  always_comb begin
    tag_in.valid = grant_any;
    tag_in.id    = grant_id;
  end

  level_arb_tag_pipe #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_pipe (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .tag_in   (tag_in),
    .tag_out  (tag_out),
    .any_valid(tags_busy)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bg_gnt      <= 1'b0;
      col_gnt     <= 1'b0;
      mem_address <= '0;
    end else begin
      bg_gnt  <= grant_any && (grant_id == ID_BG);
      col_gnt <= grant_any && (grant_id == ID_COL);
      if (grant_any) begin
        mem_address <= (grant_id == ID_COL) ? col_addr : bg_addr;
      end
    end
  end

  // The oldest tag reaches the end of the pipe exactly when mem_q holds its data.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bg_valid  <= 1'b0;
      col_valid <= 1'b0;
      bg_data   <= '0;
      col_data  <= '0;
    end else begin
      bg_valid  <= 1'b0;
      col_valid <= 1'b0;
      if (tag_out.valid) begin
        if (tag_out.id == ID_COL) begin
          col_valid <= 1'b1;
          col_data  <= mem_q;
        end else begin
          bg_valid <= 1'b1;
          bg_data  <= mem_q;
        end
      end
    end
  end

  assign busy = bg_req | col_req | tags_busy;

endmodule

// File: tb/tb_level_mem_arbiter.sv
// Randomized bench for level_mem_arbiter: READ_LATENCY=1 and =2 instances share stimulus
// and are compared against a transaction-level model of grants and returned reads.
module tb_level_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 4;

  logic          CLOCK_50 = 1'b0;
  logic          resetn   = 1'b0;
  logic          bg_req   = 1'b0;
  logic          col_req  = 1'b0;
  logic [AW-1:0] bg_addr  = '0;
  logic [AW-1:0] col_addr = '0;

  logic [1:0]    bg_gnt_w, col_gnt_w, bg_valid_w, col_valid_w, busy_w;
  logic [DW-1:0] bg_data_w  [2];
  logic [DW-1:0] col_data_w [2];
  logic [DW-1:0] mem_q_w    [2];
  logic [AW-1:0] mem_addr_w [2];
  logic [DW-1:0] q1_a, q1_b, q2_b;

  always #10 CLOCK_50 = ~CLOCK_50;

  // Level memory models: q = addr[3:0], one or two clocks behind the address.
  always @(posedge CLOCK_50) begin
    q1_a <= mem_addr_w[0][DW-1:0];
    q1_b <= mem_addr_w[1][DW-1:0];
    q2_b <= q1_b;
  end
  assign mem_q_w[0] = q1_a;
  assign mem_q_w[1] = q2_b;

  level_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_dut_rl1 (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt_w[0]), .bg_valid(bg_valid_w[0]),
    .bg_data(bg_data_w[0]),
    .col_req(col_req), .col_addr(col_addr), .col_gnt(col_gnt_w[0]), .col_valid(col_valid_w[0]),
    .col_data(col_data_w[0]),
    .mem_address(mem_addr_w[0]), .mem_q(mem_q_w[0]), .busy(busy_w[0])
  );

  level_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) u_dut_rl2 (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt_w[1]), .bg_valid(bg_valid_w[1]),
    .bg_data(bg_data_w[1]),
    .col_req(col_req), .col_addr(col_addr), .col_gnt(col_gnt_w[1]), .col_valid(col_valid_w[1]),
    .col_data(col_data_w[1]),
    .mem_address(mem_addr_w[1]), .mem_q(mem_q_w[1]), .busy(busy_w[1])
  );

  typedef struct {
    int            inst;
    int            due;
    bit            col;
    logic [DW-1:0] d;
  } rd_t;

  rd_t           pend[$];
  int            cyc;
  bit            last_col;
  logic          exp_bg_gnt, exp_col_gnt;
  logic [AW-1:0] exp_mem_addr;
  logic [DW-1:0] exp_bg_data  [2];
  logic [DW-1:0] exp_col_data [2];
  logic [1:0]    exp_bg_valid, exp_col_valid;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    last_col      = 1'b1;
    exp_bg_gnt    = 1'b0;
    exp_col_gnt   = 1'b0;
    exp_mem_addr  = '0;
    exp_bg_valid  = '0;
    exp_col_valid = '0;
    for (int i = 0; i < 2; i++) begin
      exp_bg_data[i]  = '0;
      exp_col_data[i] = '0;
    end
  endtask

  task automatic compare(input logic req_any);
    for (int i = 0; i < 2; i++) begin
      int outstanding = 0;
      foreach (pend[k]) if (pend[k].inst == i) outstanding++;
      check($sformatf("rl%0d bg_gnt", i + 1), bg_gnt_w[i], exp_bg_gnt);
      check($sformatf("rl%0d col_gnt", i + 1), col_gnt_w[i], exp_col_gnt);
      check($sformatf("rl%0d bg_valid", i + 1), bg_valid_w[i], exp_bg_valid[i]);
      check($sformatf("rl%0d col_valid", i + 1), col_valid_w[i], exp_col_valid[i]);
      check($sformatf("rl%0d bg_data", i + 1), bg_data_w[i], exp_bg_data[i]);
      check($sformatf("rl%0d col_data", i + 1), col_data_w[i], exp_col_data[i]);
      check($sformatf("rl%0d mem_address", i + 1), mem_addr_w[i], exp_mem_addr);
      check($sformatf("rl%0d busy", i + 1), busy_w[i], req_any || (outstanding != 0));
    end
  endtask

  // One clock: apply requests, predict the grant, retire reads due now, check outputs.
  task automatic step(input logic br, input logic [AW-1:0] ba, input logic cr, input logic [AW-1:0] ca);
    logic          take, pick_col;
    logic [AW-1:0] gaddr;
    bg_req   = br;
    bg_addr  = ba;
    col_req  = cr;
    col_addr = ca;
    take     = br | cr;
`ifdef LEVEL_ARB_FIXED_PRIO_EN
    pick_col = cr;
`else
    pick_col = cr && (!br || !last_col);
`endif
    @(posedge CLOCK_50);
    cyc++;
    exp_bg_gnt  = take && !pick_col;
    exp_col_gnt = take && pick_col;
    if (take) begin
      gaddr        = pick_col ? ca : ba;
      last_col     = pick_col;
      exp_mem_addr = gaddr;
      for (int i = 0; i < 2; i++) pend.push_back('{i, cyc + i + 2, pick_col, gaddr[DW-1:0]});
    end
    exp_bg_valid  = '0;
    exp_col_valid = '0;
    for (int k = pend.size() - 1; k >= 0; k--) begin
      if (pend[k].due == cyc) begin
        if (pend[k].col) begin
          exp_col_valid[pend[k].inst] = 1'b1;
          exp_col_data[pend[k].inst]  = pend[k].d;
        end else begin
          exp_bg_valid[pend[k].inst] = 1'b1;
          exp_bg_data[pend[k].inst]  = pend[k].d;
        end
        pend.delete(k);
      end
    end
    @(negedge CLOCK_50);
    compare(br | cr);
  endtask

  task automatic do_reset();
    bg_req  = 1'b0;
    col_req = 1'b0;
    resetn  = 1'b0;
    #1;
    model_reset();
    compare(1'b0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    #1;
    compare(1'b0);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    compare(1'b0);
    resetn = 1'b1;

    step(1'b1, 15'h0123, 1'b0, '0);
    idle(4);

    for (int j = 0; j < 6; j++) step(1'b1, AW'($urandom), 1'b1, AW'($urandom));
    idle(4);

    step(1'b0, '0, 1'b1, 15'h7FFF);
    idle(4);

    step(1'b1, 15'h0055, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    do_reset();
    idle(4);

    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 9) < 6), AW'($urandom), ($urandom_range(0, 9) < 6), AW'($urandom));
      end
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
